// File: rtl/axi_xbar_1to2.sv
// AXI4 one-master to two-slave address-decoding demux.
// Unmapped addresses are answered by an internal DECERR responder.
module axi_xbar_1to2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] S0_MASK = 32'hF800_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK = 32'hF000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  // upstream
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [3:0]              s_awid,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [3:0]              s_bid,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [3:0]              s_arid,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic [3:0]              s_rid,
  // slave 0
  output logic                    m0_awvalid,
  input  logic                    m0_awready,
  output logic [ADDR_WIDTH-1:0]   m0_awaddr,
  output logic [3:0]              m0_awid,
  output logic [7:0]              m0_awlen,
  output logic [2:0]              m0_awsize,
  output logic [1:0]              m0_awburst,
  output logic                    m0_wvalid,
  input  logic                    m0_wready,
  output logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic [DATA_WIDTH/8-1:0] m0_wstrb,
  output logic                    m0_wlast,
  input  logic                    m0_bvalid,
  output logic                    m0_bready,
  input  logic [3:0]              m0_bid,
  input  logic [1:0]              m0_bresp,
  output logic                    m0_arvalid,
  input  logic                    m0_arready,
  output logic [ADDR_WIDTH-1:0]   m0_araddr,
  output logic [3:0]              m0_arid,
  output logic [7:0]              m0_arlen,
  output logic [2:0]              m0_arsize,
  output logic [1:0]              m0_arburst,
  input  logic                    m0_rvalid,
  output logic                    m0_rready,
  input  logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic [1:0]              m0_rresp,
  input  logic                    m0_rlast,
  input  logic [3:0]              m0_rid,
  // slave 1
  output logic                    m1_awvalid,
  input  logic                    m1_awready,
  output logic [ADDR_WIDTH-1:0]   m1_awaddr,
  output logic [3:0]              m1_awid,
  output logic [7:0]              m1_awlen,
  output logic [2:0]              m1_awsize,
  output logic [1:0]              m1_awburst,
  output logic                    m1_wvalid,
  input  logic                    m1_wready,
  output logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_wstrb,
  output logic                    m1_wlast,
  input  logic                    m1_bvalid,
  output logic                    m1_bready,
  input  logic [3:0]              m1_bid,
  input  logic [1:0]              m1_bresp,
  output logic                    m1_arvalid,
  input  logic                    m1_arready,
  output logic [ADDR_WIDTH-1:0]   m1_araddr,
  output logic [3:0]              m1_arid,
  output logic [7:0]              m1_arlen,
  output logic [2:0]              m1_arsize,
  output logic [1:0]              m1_arburst,
  input  logic                    m1_rvalid,
  output logic                    m1_rready,
  input  logic [DATA_WIDTH-1:0]   m1_rdata,
  input  logic [1:0]              m1_rresp,
  input  logic                    m1_rlast,
  input  logic [3:0]              m1_rid
);

  typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_ERR} sel_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_e;
  typedef enum logic [2:0] {
    W_IDLE, W_XFER, W_RESP, W_ERR_D, W_ERR_B
  } w_state_e;

  function automatic sel_e decode(input logic [ADDR_WIDTH-1:0] a);
    if ((a & S0_MASK) == S0_BASE) return SEL_S0;
    else if ((a & S1_MASK) == S1_BASE) return SEL_S1;
    else return SEL_ERR;
  endfunction

  // Payloads fan out unconditionally; only valid/ready are steered.
  assign m0_awaddr  = s_awaddr;
  assign m0_awid    = s_awid;
  assign m0_awlen   = s_awlen;
  assign m0_awsize  = s_awsize;
  assign m0_awburst = s_awburst;
  assign m0_wdata   = s_wdata;
  assign m0_wstrb   = s_wstrb;
  assign m0_wlast   = s_wlast;
  assign m0_araddr  = s_araddr;
  assign m0_arid    = s_arid;
  assign m0_arlen   = s_arlen;
  assign m0_arsize  = s_arsize;
  assign m0_arburst = s_arburst;
  assign m1_awaddr  = s_awaddr;
  assign m1_awid    = s_awid;
  assign m1_awlen   = s_awlen;
  assign m1_awsize  = s_awsize;
  assign m1_awburst = s_awburst;
  assign m1_wdata   = s_wdata;
  assign m1_wstrb   = s_wstrb;
  assign m1_wlast   = s_wlast;
  assign m1_araddr  = s_araddr;
  assign m1_arid    = s_arid;
  assign m1_arlen   = s_arlen;
  assign m1_arsize  = s_arsize;
  assign m1_arburst = s_arburst;

  r_state_e   r_state, r_next;
  sel_e       rsel;
  logic [3:0] rid_q;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      rsel    <= SEL_S0;
      rid_q   <= '0;
      cnt     <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && s_arvalid)
        rsel <= decode(s_araddr);
      if (r_state == R_ADDR && rsel == SEL_ERR && s_arvalid) begin
        rid_q <= s_arid;
        cnt   <= s_arlen;
      end
      if (r_state == R_ERR && s_rready && cnt != 8'd0)
        cnt <= cnt - 8'd1;
    end
  end

  always_comb begin
    r_next     = r_state;
    s_arready  = 1'b0;
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    m0_rready  = 1'b0;
    m1_rready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rdata    = '0;
    s_rresp    = 2'b00;
    s_rlast    = 1'b0;
    s_rid      = '0;
    case (r_state)
      R_IDLE: if (s_arvalid) r_next = R_ADDR;
      R_ADDR: begin
        case (rsel)
          SEL_S0: begin
            m0_arvalid = s_arvalid;
            s_arready  = m0_arready;
          end
          SEL_S1: begin
            m1_arvalid = s_arvalid;
            s_arready  = m1_arready;
          end
          default: s_arready = 1'b1;
        endcase
        if (s_arvalid && s_arready)
          r_next = (rsel == SEL_ERR) ? R_ERR : R_DATA;
      end
      R_DATA: begin
        case (rsel)
          SEL_S0: begin
            s_rvalid  = m0_rvalid;
            s_rdata   = m0_rdata;
            s_rresp   = m0_rresp;
            s_rlast   = m0_rlast;
            s_rid     = m0_rid;
            m0_rready = s_rready;
          end
          SEL_S1: begin
            s_rvalid  = m1_rvalid;
            s_rdata   = m1_rdata;
            s_rresp   = m1_rresp;
            s_rlast   = m1_rlast;
            s_rid     = m1_rid;
            m1_rready = s_rready;
          end
          default: ;
        endcase
        if (rsel == SEL_ERR || (s_rvalid && s_rready && s_rlast))
          r_next = R_IDLE;
      end
      R_ERR: begin
        s_rvalid = 1'b1;
        s_rresp  = 2'b11;
        s_rid    = rid_q;
        s_rlast  = (cnt == 8'd0);
        if (s_rready && s_rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  w_state_e   w_state, w_next;
  sel_e       wsel;
  logic [3:0] bid_q;
  logic       aw_done, w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      wsel    <= SEL_S0;
      bid_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && s_awvalid)
        wsel <= decode(s_awaddr);
      if (w_state == W_XFER && wsel == SEL_ERR && s_awvalid)
        bid_q <= s_awid;
      if (w_state == W_XFER) begin
        if (s_awvalid && s_awready) aw_done <= 1'b1;
        if (s_wvalid && s_wready && s_wlast) w_done <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next     = w_state;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    s_bid      = '0;
    s_bresp    = 2'b00;
    m0_awvalid = 1'b0;
    m1_awvalid = 1'b0;
    m0_wvalid  = 1'b0;
    m1_wvalid  = 1'b0;
    m0_bready  = 1'b0;
    m1_bready  = 1'b0;
    case (w_state)
      W_IDLE: if (s_awvalid) w_next = W_XFER;
      W_XFER: begin
        case (wsel)
          SEL_S0: begin
            m0_awvalid = s_awvalid & ~aw_done;
            s_awready  = m0_awready & ~aw_done;
            m0_wvalid  = s_wvalid & ~w_done;
            s_wready   = m0_wready & ~w_done;
          end
          SEL_S1: begin
            m1_awvalid = s_awvalid & ~aw_done;
            s_awready  = m1_awready & ~aw_done;
            m1_wvalid  = s_wvalid & ~w_done;
            s_wready   = m1_wready & ~w_done;
          end
          default: s_awready = 1'b1;
        endcase
        if (wsel == SEL_ERR) begin
          if (s_awvalid) w_next = W_ERR_D;
        end else if ((aw_done || (s_awvalid && s_awready)) &&
                     (w_done || (s_wvalid && s_wready && s_wlast))) begin
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        case (wsel)
          SEL_S0: begin
            s_bvalid  = m0_bvalid;
            s_bid     = m0_bid;
            s_bresp   = m0_bresp;
            m0_bready = s_bready;
          end
          SEL_S1: begin
            s_bvalid  = m1_bvalid;
            s_bid     = m1_bid;
            s_bresp   = m1_bresp;
            m1_bready = s_bready;
          end
          default: ;
        endcase
        if (wsel == SEL_ERR || (s_bvalid && s_bready))
          w_next = W_IDLE;
      end
      W_ERR_D: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) w_next = W_ERR_B;
      end
      W_ERR_B: begin
        s_bvalid = 1'b1;
        s_bresp  = 2'b11;
        s_bid    = bid_q;
        if (s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_xbar_1to2.sv
// Directed bench for axi_xbar_1to2 with hand-driven slave responses.
module tb_axi_xbar_1to2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic s_bvalid, s_bready, s_arvalid, s_arready;
  logic s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [3:0] s_awid, s_bid, s_arid, s_rid;
  logic [7:0] s_awlen, s_arlen;
  logic [2:0] s_awsize, s_arsize;
  logic [1:0] s_awburst, s_arburst, s_bresp, s_rresp;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [DW/8-1:0] s_wstrb;

  logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast;
  logic m0_bvalid, m0_bready, m0_arvalid, m0_arready;
  logic m0_rvalid, m0_rready, m0_rlast;
  logic [AW-1:0] m0_awaddr, m0_araddr;
  logic [3:0] m0_awid, m0_bid, m0_arid, m0_rid;
  logic [7:0] m0_awlen, m0_arlen;
  logic [2:0] m0_awsize, m0_arsize;
  logic [1:0] m0_awburst, m0_arburst, m0_bresp, m0_rresp;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [DW/8-1:0] m0_wstrb;

  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast;
  logic m1_bvalid, m1_bready, m1_arvalid, m1_arready;
  logic m1_rvalid, m1_rready, m1_rlast;
  logic [AW-1:0] m1_awaddr, m1_araddr;
  logic [3:0] m1_awid, m1_bid, m1_arid, m1_rid;
  logic [7:0] m1_awlen, m1_arlen;
  logic [2:0] m1_awsize, m1_arsize;
  logic [1:0] m1_awburst, m1_arburst, m1_bresp, m1_rresp;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [DW/8-1:0] m1_wstrb;

  int checks = 0;
  int errors = 0;
  int beat;

  axi_xbar_1to2 dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
    .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_awaddr(m0_awaddr), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
    .m0_awsize(m0_awsize), .m0_awburst(m0_awburst),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bid(m0_bid),
    .m0_bresp(m0_bresp),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bid(m1_bid),
    .m1_bresp(m1_bresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " s_arready"}, s_arready, 0);
    chk({tag, " s_rvalid"}, s_rvalid, 0);
    chk({tag, " s_awready"}, s_awready, 0);
    chk({tag, " s_wready"}, s_wready, 0);
    chk({tag, " s_bvalid"}, s_bvalid, 0);
    chk({tag, " m0 valids"},
        {m0_arvalid, m0_awvalid, m0_wvalid}, 0);
    chk({tag, " m1 valids"},
        {m1_arvalid, m1_awvalid, m1_wvalid}, 0);
    chk({tag, " readies"},
        {m0_rready, m0_bready, m1_rready, m1_bready}, 0);
  endtask

  initial begin
    reset = 1'b1;
    {s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready} = '0;
    s_awaddr = '0; s_araddr = '0; s_awid = '0; s_arid = '0;
    s_awlen = '0; s_arlen = '0; s_awsize = 3'd2; s_arsize = 3'd2;
    s_awburst = 2'b01; s_arburst = 2'b01; s_wdata = '0; s_wstrb = '1;
    {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid, m0_rlast} = '0;
    {m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid, m1_rlast} = '0;
    m0_bid = '0; m0_bresp = '0; m0_rdata = '0; m0_rresp = '0; m0_rid = '0;
    m1_bid = '0; m1_bresp = '0; m1_rdata = '0; m1_rresp = '0; m1_rid = '0;
    step();
    step();
    chk_idle("reset");
    reset = 1'b0;

    // Single-beat read to S0
    s_arvalid = 1'b1; s_araddr = 32'h8000_0010; s_arid = 4'd3;
    s_arlen = 8'd0;
    #1;
    chk("rd0 idle m0_arvalid", m0_arvalid, 0);
    step();
    chk("rd0 m0_arvalid", m0_arvalid, 1);
    chk("rd0 m1_arvalid", m1_arvalid, 0);
    chk("rd0 m0_araddr", m0_araddr, 32'h8000_0010);
    chk("rd0 s_arready low", s_arready, 0);
    m0_arready = 1'b1;
    #1;
    chk("rd0 s_arready", s_arready, 1);
    step();
    s_arvalid = 1'b0; m0_arready = 1'b0;
    m0_rvalid = 1'b1; m0_rdata = 32'hDEAD_0001; m0_rid = 4'd3;
    m0_rlast = 1'b1; s_rready = 1'b1;
    #1;
    chk("rd0 s_rvalid", s_rvalid, 1);
    chk("rd0 s_rdata", s_rdata, 32'hDEAD_0001);
    chk("rd0 s_rid", s_rid, 3);
    chk("rd0 s_rlast", s_rlast, 1);
    chk("rd0 m0_rready", m0_rready, 1);
    chk("rd0 m1_rready", m1_rready, 0);
    step();
    m0_rvalid = 1'b0; m0_rlast = 1'b0; s_rready = 1'b0;
    #1;
    chk("rd0 done s_rvalid", s_rvalid, 0);

    // Burst read to S1 with toggling rready
    s_arvalid = 1'b1; s_araddr = 32'h1000_0000; s_arid = 4'd6;
    s_arlen = 8'd3; m1_arready = 1'b1;
    step();
    #1;
    chk("rd1 m1_arvalid", m1_arvalid, 1);
    chk("rd1 m0_arvalid", m0_arvalid, 0);
    chk("rd1 s_arready", s_arready, 1);
    step();
    s_arvalid = 1'b0; m1_arready = 1'b0;
    m1_rvalid = 1'b1; m1_rid = 4'd6; m1_rdata = 32'h100; m1_rlast = 1'b0;
    beat = 0;
    for (int cyc = 0; cyc < 20 && beat < 4; cyc++) begin
      s_rready = cyc[0];
      #1;
      chk("rd1 m1_rready", m1_rready, s_rready);
      if (s_rvalid && s_rready) begin
        chk("rd1 s_rdata", s_rdata, 32'h100 + beat);
        chk("rd1 s_rlast", s_rlast, beat == 3);
        beat++;
      end
      step();
      m1_rdata = 32'h100 + beat;
      m1_rlast = (beat == 3);
      if (beat == 4) m1_rvalid = 1'b0;
    end
    chk("rd1 beats", beat, 4);
    s_rready = 1'b0; m1_rlast = 1'b0;
    #1;
    chk("rd1 done s_rvalid", s_rvalid, 0);

    // Unmapped read: DECERR responder
    s_arvalid = 1'b1; s_araddr = 32'h0000_1000; s_arid = 4'd5;
    s_arlen = 8'd1;
    step();
    chk("err_rd s_arready", s_arready, 1);
    chk("err_rd arvalids", {m0_arvalid, m1_arvalid}, 0);
    step();
    s_arvalid = 1'b0; s_rready = 1'b1;
    #1;
    chk("err_rd b1 valid", s_rvalid, 1);
    chk("err_rd b1 data", s_rdata, 0);
    chk("err_rd b1 resp", s_rresp, 2'b11);
    chk("err_rd b1 rid", s_rid, 5);
    chk("err_rd b1 last", s_rlast, 0);
    chk("err_rd s_arready gone", s_arready, 0);
    step();
    chk("err_rd b2 valid", s_rvalid, 1);
    chk("err_rd b2 last", s_rlast, 1);
    chk("err_rd b2 rid", s_rid, 5);
    step();
    s_rready = 1'b0;
    #1;
    chk("err_rd done", s_rvalid, 0);

    // Write to S1 with AW stalled five cycles
    s_awvalid = 1'b1; s_awaddr = 32'h1000_0040; s_awid = 4'd2;
    s_awlen = 8'd0; s_wvalid = 1'b1; s_wdata = 32'hCAFE_0000;
    s_wlast = 1'b1; m1_wready = 1'b1; m1_awready = 1'b0;
    #1;
    chk("wr1 idle s_wready", s_wready, 0);
    step();
    chk("wr1 m1_awvalid", m1_awvalid, 1);
    chk("wr1 m1_wvalid", m1_wvalid, 1);
    chk("wr1 m0_wvalid", m0_wvalid, 0);
    chk("wr1 s_wready", s_wready, 1);
    chk("wr1 m1_wdata", m1_wdata, 32'hCAFE_0000);
    chk("wr1 s_awready", s_awready, 0);
    step();
    s_wvalid = 1'b0; s_wlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wr1 aw held", m1_awvalid, 1);
      chk("wr1 w done", m1_wvalid, 0);
      step();
    end
    m1_awready = 1'b1;
    #1;
    chk("wr1 s_awready", s_awready, 1);
    step();
    m1_awready = 1'b0;
    s_awaddr = 32'hF000_0000; s_awid = 4'd7; s_awlen = 8'd2;
    #1;
    chk("wr1 resp 2nd aw blocked", s_awready, 0);
    chk("wr1 resp m1_awvalid", m1_awvalid, 0);
    chk("wr1 resp no b", s_bvalid, 0);
    step();
    m1_bvalid = 1'b1; m1_bid = 4'd2; m1_bresp = 2'b00; s_bready = 1'b1;
    #1;
    chk("wr1 s_bvalid", s_bvalid, 1);
    chk("wr1 s_bid", s_bid, 2);
    chk("wr1 s_bresp", s_bresp, 2'b00);
    chk("wr1 m1_bready", m1_bready, 1);
    chk("wr1 m0_bready", m0_bready, 0);
    chk("wr1 b 2nd aw blocked", s_awready, 0);
    step();
    m1_bvalid = 1'b0; s_bready = 1'b0;
    #1;
    chk("wr1 idle after b", s_awready, 0);
    chk("wr1 idle s_bvalid", s_bvalid, 0);

    // Unmapped write from the queued AW
    step();
    chk("err_wr s_awready", s_awready, 1);
    chk("err_wr awvalids", {m0_awvalid, m1_awvalid}, 0);
    chk("err_wr s_wready early", s_wready, 0);
    step();
    s_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_wvalid = 1'b1; s_wlast = (i == 2);
      #1;
      chk("err_wr s_wready", s_wready, 1);
      chk("err_wr wvalids", {m0_wvalid, m1_wvalid}, 0);
      step();
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    #1;
    chk("err_wr s_bvalid", s_bvalid, 1);
    chk("err_wr s_bresp", s_bresp, 2'b11);
    chk("err_wr s_bid", s_bid, 7);
    chk("err_wr s_wready off", s_wready, 0);
    step();
    chk("err_wr b held", s_bvalid, 1);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    #1;
    chk("err_wr done", s_bvalid, 0);

    // Concurrent read S0 / write S1, then reset mid-burst
    s_arvalid = 1'b1; s_araddr = 32'h8000_0100; s_arid = 4'd1;
    s_arlen = 8'd3;
    s_awvalid = 1'b1; s_awaddr = 32'h1000_0000; s_awid = 4'd4;
    s_awlen = 8'd0; s_wvalid = 1'b1; s_wlast = 1'b1;
    m0_arready = 1'b1; m1_awready = 1'b1; m1_wready = 1'b1;
    step();
    chk("cc m0_arvalid", m0_arvalid, 1);
    chk("cc m1_awvalid", m1_awvalid, 1);
    chk("cc m1_wvalid", m1_wvalid, 1);
    chk("cc cross", {m0_awvalid, m0_wvalid, m1_arvalid}, 0);
    chk("cc readies", {s_arready, s_awready, s_wready}, 3'b111);
    step();
    {s_arvalid, s_awvalid, s_wvalid, s_wlast} = '0;
    {m0_arready, m1_awready, m1_wready} = '0;
    m1_bvalid = 1'b1; m1_bid = 4'd4; s_bready = 1'b1;
    m0_rvalid = 1'b1; m0_rdata = 32'hA0; m0_rid = 4'd1; m0_rlast = 1'b0;
    s_rready = 1'b1;
    #1;
    chk("cc s_bvalid", s_bvalid, 1);
    chk("cc s_bid", s_bid, 4);
    chk("cc s_rvalid", s_rvalid, 1);
    chk("cc s_rdata b1", s_rdata, 32'hA0);
    chk("cc m0_rready", m0_rready, 1);
    step();
    m1_bvalid = 1'b0; s_bready = 1'b0; m0_rdata = 32'hA1;
    #1;
    chk("cc b done", s_bvalid, 0);
    chk("cc s_rdata b2", s_rdata, 32'hA1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("midreset");
    m0_rvalid = 1'b0; s_rready = 1'b0;

    // Read after reset
    s_arvalid = 1'b1; s_araddr = 32'h8000_0000; s_arid = 4'd9;
    s_arlen = 8'd0;
    step();
    chk("post m0_arvalid", m0_arvalid, 1);
    chk("post m0_arid", m0_arid, 9);
    m0_arready = 1'b1;
    step();
    s_arvalid = 1'b0; m0_arready = 1'b0;
    m0_rvalid = 1'b1; m0_rdata = 32'h55; m0_rid = 4'd9; m0_rlast = 1'b1;
    s_rready = 1'b1;
    #1;
    chk("post s_rvalid", s_rvalid, 1);
    chk("post s_rid", s_rid, 9);
    chk("post s_rdata", s_rdata, 32'h55);
    step();
    m0_rvalid = 1'b0; m0_rlast = 1'b0; s_rready = 1'b0;
    #1;
    chk("post idle", s_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
